multi_mem_sequencer: RTL
========================

// Module: multi_mem_sequencer
// PURPOSE
//  Multi-cycle sequencer for store-multiple (op 59) / load-multiple (op 51). Started by decoder swm_o;
//  walks the register mask low-to-high, one data-memory word per cycle, and stalls PC/fetch until done.
//  Sits between decoder, register file (spare read/write port) and Data_Memory address/data mux.
// PARAMETERS
//  MASK_W      16   register-mask width (instr[15:0]); bit i selects register REG_OFFSET+i
//  REG_OFFSET  16   first register covered by bit 0 (default maps $16..$31)
//  ADDR_W      32   memory address / data width
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_i        in   1        asynchronous, active-high reset
//  start_i      in   1        decoder swm_o for current instruction
//  load_i       in   1        1 = load-multiple (decoder memread_o), 0 = store-multiple
//  base_addr_i  in   ADDR_W   ALU result rs+imm, sampled on accepted start
//  reg_mask_i   in   MASK_W   register mask, sampled on accepted start
//  reg_rdata_i  in   ADDR_W   register-file read data for reg_raddr_o (combinational)
//  mem_rdata_i  in   ADDR_W   data-memory read data for mem_addr_o (combinational read)
//  stall_o      out  1        hold PC / block normal writeback
//  busy_o       out  1        sequencer not IDLE
//  done_o       out  1        one-cycle completion pulse
//  mem_addr_o   out  ADDR_W   word address of current access
//  mem_wdata_o  out  ADDR_W   store data (= reg_rdata_i)
//  mem_we_o     out  1        memory write strobe
//  mem_re_o     out  1        memory read strobe
//  reg_raddr_o  out  5        register read index (store)
//  reg_waddr_o  out  5        register write index (load)
//  reg_wdata_o  out  ADDR_W   load data (= mem_rdata_i)
//  reg_we_o     out  1        register write strobe
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched mask/base/index = 0. Reset mid-run aborts instantly, no further strobes.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start_i=1 and mask!=0 -> stall_o=1 (combinational, same cycle); latch mask, load_i,
//        base={base_addr_i[ADDR_W-1:2],2'b00}; count=0; next RUN. No memory access this cycle.
//        start_i=1 and mask==0 -> next DONE directly, no access, stall_o=1 this cycle only.
//  RUN: k = lowest set bit of remaining mask; mem_addr_o = base + 4*count; reg index = REG_OFFSET+k.
//       store: mem_we_o=1, mem_wdata_o=reg_rdata_i. load: mem_re_o=1, reg_we_o=1 in same cycle.
//       Clock edge: clear bit k, count++. Remaining mask becomes 0 -> DONE. stall_o=1, busy_o=1.
//  DONE: done_o=1, stall_o=0, busy_o=1, no strobes; start_i ignored (same instruction still decoded); next IDLE.
//  Latency: N set bits -> N+2 cycles start-to-IDLE; PC advances at end of DONE cycle.
//  Address wraps modulo 2^ADDR_W; count width clog2(MASK_W+1).
//  Register index wider than 31 truncates to 5 bits; load to $0 issues reg_we_o (regfile ignores).
//  Strobes (mem_we_o/mem_re_o/reg_we_o) never asserted outside RUN; mem_we_o and reg_we_o mutually exclusive.
//  start_i while RUN/DONE: ignored; inputs changing after accepted start: no effect.
// STRUCTURE
//  Package mms_pkg: state encoding (IDLE/RUN/DONE), WORD_BYTES=4, op codes OP_SWM=6'd59, OP_LWM=6'd51.
//  Sub-module mask_prio_enc: combinational lowest-set-bit encoder (MASK_W in -> index, valid out).
//  Top: FSM, mask/base/count registers, output muxes.
// TESTING
//  Store, mask=16'h0005, base=0x100 -> writes $16 @0x100, $18 @0x104; done_o cycle 4; stall 3 cycles.
//  Load, mask=16'h8000, base=0x203 -> one read @0x200, reg_we_o to $31 with mem data; done cycle 3.
//  mask=16'h0000 start -> no strobes, done_o next cycle, stall_o high one cycle only.
//  mask=16'hFFFF store, base=0xFFFF_FFF8 -> 16 writes, addresses wrap 0xFFFF_FFF8,0xFFFF_FFFC,0x0...
//  rst_i asserted in 3rd RUN cycle of 16'h00FF load -> all outputs 0 immediately, IDLE, restart works.
//  start_i held high through DONE and one cycle after -> second run only begins from IDLE, never in DONE.

Source files
------------

// File: rtl/mms_pkg.sv
// Shared definitions for the load/store-multiple sequencer: state encoding,
// word size and the opcodes that start it.
package mms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [5:0] OP_SWM     = 6'd59;
    localparam logic [5:0] OP_LWM     = 6'd51;

    // Width of an index into an n-bit mask, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_mem_sequencer_if.sv
// Bundle of decoder, register-file and data-memory signals around the
// sequencer. The slave side is the sequencer itself.
interface multi_mem_sequencer_if #(
    parameter int MASK_W = 16,
    parameter int ADDR_W = 32
);
    logic              start_i;
    logic              load_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [MASK_W-1:0] reg_mask_i;
    logic [ADDR_W-1:0] reg_rdata_i;
    logic [ADDR_W-1:0] mem_rdata_i;

    logic              stall_o;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [ADDR_W-1:0] mem_wdata_o;
    logic              mem_we_o;
    logic              mem_re_o;
    logic [4:0]        reg_raddr_o;
    logic [4:0]        reg_waddr_o;
    logic [ADDR_W-1:0] reg_wdata_o;
    logic              reg_we_o;

    modport slave (
        input  start_i, load_i, base_addr_i, reg_mask_i, reg_rdata_i, mem_rdata_i,
        output stall_o, busy_o, done_o, mem_addr_o, mem_wdata_o, mem_we_o,
               mem_re_o, reg_raddr_o, reg_waddr_o, reg_wdata_o, reg_we_o
    );

    modport master (
        output start_i, load_i, base_addr_i, reg_mask_i, reg_rdata_i, mem_rdata_i,
        input  stall_o, busy_o, done_o, mem_addr_o, mem_wdata_o, mem_we_o,
               mem_re_o, reg_raddr_o, reg_waddr_o, reg_wdata_o, reg_we_o
    );
endinterface

// File: rtl/mask_prio_enc.sv
// Combinational lowest-set-bit encoder: idx is the position of the least
// significant 1 in mask, valid is set when any bit is set.
module mask_prio_enc #(
    parameter int MASK_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Scan from the top down so the last hit, the lowest bit, wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_mem_sequencer.sv
// Store-/load-multiple sequencer: walks a register mask low-to-high, one
// data-memory word per cycle, holding the PC stalled until the walk ends.
module multi_mem_sequencer
    import mms_pkg::*;
#(
    parameter int MASK_W     = 16,
    parameter int REG_OFFSET = 16,
    parameter int ADDR_W     = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    multi_mem_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(MASK_W + 1);
    localparam int IDX_W = idx_width(MASK_W);

    state_t            state_reg, state_next;
    logic [MASK_W-1:0] mask_reg, mask_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              load_reg, load_next;

    logic [IDX_W-1:0]  low_idx;
    logic              low_valid;
    logic [MASK_W-1:0] low_bit;
    logic [MASK_W-1:0] mask_left;
    logic [4:0]        reg_idx;
    logic [ADDR_W-1:0] access_addr;
    logic              run_active;

    mask_prio_enc #(
        .MASK_W(MASK_W),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .mask (mask_reg),
        .idx  (low_idx),
        .valid(low_valid)
    );

    assign low_bit     = MASK_W'(1) << low_idx;
    assign mask_left   = mask_reg & ~low_bit;
    // Indices past $31 deliberately wrap into the 5-bit register space.
    assign reg_idx     = 5'(REG_OFFSET + 32'(low_idx));
    assign access_addr = base_reg + ADDR_W'(count_reg) * ADDR_W'(WORD_BYTES);
    assign run_active  = (state_reg == ST_RUN) && low_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            mask_reg  <= '0;
            base_reg  <= '0;
            count_reg <= '0;
            load_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            base_reg  <= base_next;
            count_reg <= count_next;
            load_reg  <= load_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        base_next  = base_reg;
        count_next = count_reg;
        load_next  = load_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (|bus.reg_mask_i) begin
                        mask_next  = bus.reg_mask_i;
                        base_next  = {bus.base_addr_i[ADDR_W-1:2], 2'b00};
                        count_next = '0;
                        load_next  = bus.load_i;
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                mask_next  = mask_left;
                count_next = count_reg + 1'b1;
                if (mask_left == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The start-cycle stall is combinational, so it is masked by reset too.
    always_comb begin
        bus.stall_o     = ((state_reg == ST_IDLE) && bus.start_i && !rst_i) ||
                          (state_reg == ST_RUN);
        bus.busy_o      = (state_reg != ST_IDLE);
        bus.done_o      = (state_reg == ST_DONE);
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_re_o    = 1'b0;
        bus.reg_raddr_o = '0;
        bus.reg_waddr_o = '0;
        bus.reg_wdata_o = '0;
        bus.reg_we_o    = 1'b0;
        if (run_active) begin
            bus.mem_addr_o = access_addr;
            if (load_reg) begin
                bus.mem_re_o    = 1'b1;
                bus.reg_we_o    = 1'b1;
                bus.reg_waddr_o = reg_idx;
                bus.reg_wdata_o = bus.mem_rdata_i;
            end else begin
                bus.mem_we_o    = 1'b1;
                bus.reg_raddr_o = reg_idx;
                bus.mem_wdata_o = bus.reg_rdata_i;
            end
        end
    end

endmodule
